// File: rtl/dmem_arbiter_if.sv
// One master's request/response channel into the data-memory arbiter.
// The master modport is the requester side; the slave modport is the arbiter side.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [2:0]        funct3;
    logic              we;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, addr, wdata, funct3, we, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, addr, wdata, funct3, we, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and single-outstanding access sequencer that shares one
// data-memory port between two masters (IDLE -> ACCESS -> RESP).
module dmem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int MEM_BYTES = 1024,
    parameter int RR_INIT   = 0
) (
    input  logic              clk,
    input  logic              rst,
    dmem_arbiter_if.slave     m0,
    dmem_arbiter_if.slave     m1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_write_data,
    output logic [2:0]        mem_funct3,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [31:0]       mem_read_data
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state;
    logic              rr_ptr;
    logic              owner;
    logic [ADDR_W-1:0] cap_addr;
    logic [31:0]       cap_wdata;
    logic [2:0]        cap_funct3;
    logic              cap_we;
    logic [31:0]       cap_rdata;
    logic              cap_err;

    logic              grant0;
    logic              grant1;
    logic              win;
    logic [ADDR_W-1:0] win_addr;
    logic [31:0]       win_wdata;
    logic [2:0]        win_funct3;
    logic              win_we;
    logic              rsp0_valid;
    logic              rsp1_valid;
    logic              rsp_take;

    // Funct3/alignment/range screen; stores only accept sb/sh/sw.
    function automatic logic is_legal(input logic we, input logic [2:0] f3,
                                      input logic [ADDR_W-1:0] a);
        logic ok;
        case (f3)
            3'b000:  ok = 1'b1;
            3'b001:  ok = ~a[0];
            3'b010:  ok = (a[1:0] == 2'b00);
            3'b100:  ok = ~we;
            3'b101:  ok = ~we & ~a[0];
            default: ok = 1'b0;
        endcase
        return ok && (a < ADDR_W'(MEM_BYTES));
    endfunction

    always_comb begin
        grant0     = (state == IDLE) && m0.req_valid && (!m1.req_valid || !rr_ptr);
        grant1     = (state == IDLE) && m1.req_valid && (!m0.req_valid || rr_ptr);
        win        = grant1;
        win_addr   = win ? m1.addr   : m0.addr;
        win_wdata  = win ? m1.wdata  : m0.wdata;
        win_funct3 = win ? m1.funct3 : m0.funct3;
        win_we     = win ? m1.we     : m0.we;
        rsp_take   = owner ? m1.rsp_ready : m0.rsp_ready;
    end

    assign m0.req_ready = grant0;
    assign m1.req_ready = grant1;

    assign rsp0_valid   = (state == RESP) && !owner;
    assign rsp1_valid   = (state == RESP) &&  owner;
    assign m0.rsp_valid = rsp0_valid;
    assign m1.rsp_valid = rsp1_valid;
    assign m0.rsp_rdata = rsp0_valid ? cap_rdata : 32'h0;
    assign m1.rsp_rdata = rsp1_valid ? cap_rdata : 32'h0;
    assign m0.rsp_err   = rsp0_valid & cap_err;
    assign m1.rsp_err   = rsp1_valid & cap_err;

    // Strobes are decoded from the state register; rst kills a write in flight.
    assign mem_addr       = cap_addr;
    assign mem_write_data = cap_wdata;
    assign mem_funct3     = cap_funct3;
    assign mem_read       = (state == ACCESS) && !cap_we;
    assign mem_write      = (state == ACCESS) &&  cap_we && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= RR_INIT[0];
            owner      <= 1'b0;
            cap_addr   <= '0;
            cap_wdata  <= '0;
            cap_funct3 <= '0;
            cap_we     <= 1'b0;
            cap_rdata  <= '0;
            cap_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        owner      <= win;
                        rr_ptr     <= ~win;
                        cap_addr   <= win_addr;
                        cap_wdata  <= win_wdata;
                        cap_funct3 <= win_funct3;
                        cap_we     <= win_we;
                        cap_rdata  <= '0;
                        if (is_legal(win_we, win_funct3, win_addr)) begin
                            cap_err <= 1'b0;
                            state   <= ACCESS;
                        end else begin
                            cap_err <= 1'b1;
                            state   <= RESP;
                        end
                    end
                end
                ACCESS: begin
                    cap_rdata <= cap_we ? 32'h0 : mem_read_data;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_take) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a byte-addressable 256-word memory model
// that returns sign/zero-extended load data combinationally.
module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [2:0]  mem_funct3;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_read_data;

    int checks = 0;
    int errors = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;

    logic [31:0] mem [0:255];

    dmem_arbiter_if #(.ADDR_W(32)) m0_if ();
    dmem_arbiter_if #(.ADDR_W(32)) m1_if ();

    dmem_arbiter #(.ADDR_W(32), .MEM_BYTES(1024), .RR_INIT(0)) dut (
        .clk            (clk),
        .rst            (rst),
        .m0             (m0_if),
        .m1             (m1_if),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_funct3     (mem_funct3),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_read_data  (mem_read_data)
    );

    always #5 clk = ~clk;

    always_comb begin
        logic [31:0] word;
        logic [7:0]  b;
        logic [15:0] h;
        word = mem[mem_addr[9:2]];
        b    = word[8*mem_addr[1:0] +: 8];
        h    = word[16*mem_addr[1] +: 16];
        case (mem_funct3)
            3'b000:  mem_read_data = {{24{b[7]}}, b};
            3'b001:  mem_read_data = {{16{h[15]}}, h};
            3'b010:  mem_read_data = word;
            3'b100:  mem_read_data = {24'h0, b};
            3'b101:  mem_read_data = {16'h0, h};
            default: mem_read_data = 32'h0;
        endcase
    end

    always @(posedge clk) begin
        if (mem_read) rd_cnt <= rd_cnt + 1;
        if (mem_write) begin
            wr_cnt <= wr_cnt + 1;
            case (mem_funct3)
                3'b000:  mem[mem_addr[9:2]][8*mem_addr[1:0] +: 8] <= mem_write_data[7:0];
                3'b001:  mem[mem_addr[9:2]][16*mem_addr[1] +: 16] <= mem_write_data[15:0];
                default: mem[mem_addr[9:2]] <= mem_write_data;
            endcase
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Runs one transaction on master m; returns data, error, cycles waiting for
    // req_ready, and edges from the accepting edge to first rsp_valid.
    task automatic txn(input int m, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er,
                       output int wait_cyc, output int lat);
        rd = 32'h0; er = 1'b0; wait_cyc = 0; lat = 0;
        if (m == 0) begin
            m0_if.req_valid = 1'b1; m0_if.we = we; m0_if.funct3 = f3;
            m0_if.addr = a; m0_if.wdata = wd;
        end else begin
            m1_if.req_valid = 1'b1; m1_if.we = we; m1_if.funct3 = f3;
            m1_if.addr = a; m1_if.wdata = wd;
        end
        #1;
        while (!(m == 0 ? m0_if.req_ready : m1_if.req_ready) && wait_cyc < 20) begin
            @(posedge clk); #1;
            wait_cyc++;
        end
        if (wait_cyc >= 20) begin
            checks++; errors++;
            $display("FAIL txn_accept m%0d: req_ready never rose, required 1", m);
            m0_if.req_valid = 1'b0; m1_if.req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        m0_if.req_valid = 1'b0; m1_if.req_valid = 1'b0;
        lat = 1;
        while (!(m == 0 ? m0_if.rsp_valid : m1_if.rsp_valid) && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (lat >= 20) begin
            checks++; errors++;
            $display("FAIL txn_rsp m%0d: rsp_valid never rose, required 1", m);
            return;
        end
        rd = (m == 0) ? m0_if.rsp_rdata : m1_if.rsp_rdata;
        er = (m == 0) ? m0_if.rsp_err   : m1_if.rsp_err;
        if (m == 0) m0_if.rsp_ready = 1'b1; else m1_if.rsp_ready = 1'b1;
        @(posedge clk); #1;
        m0_if.rsp_ready = 1'b0; m1_if.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (m0_if.req_ready !== 1'b0) begin errors++; $display("FAIL rst_m0_ready got %b want 0", m0_if.req_ready); end
        checks++; if (m1_if.req_ready !== 1'b0) begin errors++; $display("FAIL rst_m1_ready got %b want 0", m1_if.req_ready); end
        checks++; if (m0_if.rsp_valid !== 1'b0 || m1_if.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got %b%b want 00", m0_if.rsp_valid, m1_if.rsp_valid); end
        checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin errors++; $display("FAIL rst_strobes got %b%b want 00", mem_read, mem_write); end
        checks++; if (mem_addr !== 32'h0 || mem_write_data !== 32'h0 || mem_funct3 !== 3'h0) begin errors++; $display("FAIL rst_mem_bus got %h %h %h want 0 0 0", mem_addr, mem_write_data, mem_funct3); end
        checks++; if (m0_if.rsp_rdata !== 32'h0 || m0_if.rsp_err !== 1'b0) begin errors++; $display("FAIL rst_rsp_data got %h %b want 0 0", m0_if.rsp_rdata, m0_if.rsp_err); end
    endtask

    task automatic test_word();
        logic [31:0] rd; logic er; int w, lat;
        txn(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, er, w, lat);
        checks++; if (er !== 1'b0 || lat != 2) begin errors++; $display("FAIL sw_rsp got err=%b lat=%0d want err=0 lat=2", er, lat); end
        txn(0, 1'b0, 3'b010, 32'h10, 32'h0, rd, er, w, lat);
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data got %h want deadbeef", rd); end
        checks++; if (er !== 1'b0 || lat != 2) begin errors++; $display("FAIL lw_rsp got err=%b lat=%0d want err=0 lat=2", er, lat); end
    endtask

    task automatic test_round_robin();
        int n = 0;
        int cyc = 0;
        logic [3:0] want = 4'b1010;
        do_reset();
        m0_if.rsp_ready = 1'b1; m1_if.rsp_ready = 1'b1;
        m0_if.req_valid = 1'b1; m0_if.we = 1'b0; m0_if.funct3 = 3'b010; m0_if.addr = 32'h10; m0_if.wdata = 32'h0;
        m1_if.req_valid = 1'b1; m1_if.we = 1'b0; m1_if.funct3 = 3'b010; m1_if.addr = 32'h14; m1_if.wdata = 32'h0;
        while (n < 4 && cyc < 40) begin
            #1;
            if (m0_if.req_ready || m1_if.req_ready) begin
                checks++;
                if (m0_if.req_ready === m1_if.req_ready || m1_if.req_ready !== want[n]) begin
                    errors++;
                    $display("FAIL rr_grant%0d got m0=%b m1=%b want m%0d only", n, m0_if.req_ready, m1_if.req_ready, want[n]);
                end
                n++;
            end
            @(posedge clk);
            cyc++;
        end
        checks++; if (n != 4) begin errors++; $display("FAIL rr_count got %0d grants want 4", n); end
        #1;
        m0_if.req_valid = 1'b0; m1_if.req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        m0_if.rsp_ready = 1'b0; m1_if.rsp_ready = 1'b0;
    endtask

    task automatic test_byte_half();
        logic [31:0] rd; logic er; int w, lat;
        txn(0, 1'b1, 3'b000, 32'h21, 32'h00000080, rd, er, w, lat);
        txn(1, 1'b0, 3'b000, 32'h21, 32'h0, rd, er, w, lat);
        checks++; if (rd !== 32'hFFFFFF80 || er !== 1'b0) begin errors++; $display("FAIL lb got %h err=%b want ffffff80 0", rd, er); end
        txn(0, 1'b0, 3'b100, 32'h21, 32'h0, rd, er, w, lat);
        checks++; if (rd !== 32'h00000080) begin errors++; $display("FAIL lbu got %h want 00000080", rd); end
        txn(1, 1'b1, 3'b001, 32'h22, 32'h00001234, rd, er, w, lat);
        txn(0, 1'b0, 3'b101, 32'h22, 32'h0, rd, er, w, lat);
        checks++; if (rd !== 32'h00001234) begin errors++; $display("FAIL lhu got %h want 00001234", rd); end
        txn(1, 1'b0, 3'b010, 32'h20, 32'h0, rd, er, w, lat);
        checks++; if (rd !== 32'h12348000) begin errors++; $display("FAIL lw_merged got %h want 12348000", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int w, lat, r0, w0;
        logic        v_we [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [2:0]  v_f3 [4] = '{3'b010, 3'b001, 3'b010, 3'b100};
        logic [31:0] v_a  [4] = '{32'h13, 32'h05, 32'h400, 32'h0};
        for (int i = 0; i < 4; i++) begin
            r0 = rd_cnt; w0 = wr_cnt;
            txn(i % 2, v_we[i], v_f3[i], v_a[i], 32'hFFFFFFFF, rd, er, w, lat);
            checks++;
            if (er !== 1'b1 || rd !== 32'h0 || lat != 1) begin
                errors++;
                $display("FAIL err_rsp%0d got err=%b rdata=%h lat=%0d want 1 0 1", i, er, rd, lat);
            end
            checks++;
            if (rd_cnt != r0 || wr_cnt != w0) begin
                errors++;
                $display("FAIL err_strobe%0d got rd=%0d wr=%0d want 0 0", i, rd_cnt - r0, wr_cnt - w0);
            end
        end
    endtask

    task automatic test_backpressure();
        int cyc = 0;
        m1_if.req_valid = 1'b1; m1_if.we = 1'b0; m1_if.funct3 = 3'b010; m1_if.addr = 32'h10; m1_if.wdata = 32'h0;
        #1;
        while (!m1_if.req_ready && cyc < 20) begin @(posedge clk); #1; cyc++; end
        @(posedge clk); #1;
        m1_if.req_valid = 1'b0;
        m0_if.req_valid = 1'b1; m0_if.we = 1'b0; m0_if.funct3 = 3'b010; m0_if.addr = 32'h20; m0_if.wdata = 32'h0;
        #1;
        checks++; if (m0_if.req_ready !== 1'b0) begin errors++; $display("FAIL bp_access_ready got %b want 0", m0_if.req_ready); end
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (m1_if.rsp_valid !== 1'b1 || m1_if.rsp_rdata !== 32'hDEADBEEF || m1_if.rsp_err !== 1'b0 || m0_if.req_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d got v=%b d=%h e=%b m0rdy=%b want 1 deadbeef 0 0", i, m1_if.rsp_valid, m1_if.rsp_rdata, m1_if.rsp_err, m0_if.req_ready);
            end
            @(posedge clk); #1;
        end
        m1_if.rsp_ready = 1'b1;
        #1;
        checks++; if (m0_if.req_ready !== 1'b0) begin errors++; $display("FAIL bp_release_ready got %b want 0", m0_if.req_ready); end
        @(posedge clk); #1;
        m1_if.rsp_ready = 1'b0;
        #1;
        checks++; if (m0_if.req_ready !== 1'b1 || m1_if.rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_m0_grant got rdy=%b m1v=%b want 1 0", m0_if.req_ready, m1_if.rsp_valid); end
        @(posedge clk); #1;
        m0_if.req_valid = 1'b0;
        cyc = 0;
        while (!m0_if.rsp_valid && cyc < 20) begin @(posedge clk); #1; cyc++; end
        checks++; if (m0_if.rsp_rdata !== 32'h12348000 || cyc != 1) begin errors++; $display("FAIL bp_m0_rsp got %h after %0d want 12348000 after 1", m0_if.rsp_rdata, cyc); end
        m0_if.rsp_ready = 1'b1;
        @(posedge clk); #1;
        m0_if.rsp_ready = 1'b0;
    endtask

    task automatic test_reset_in_access();
        logic [31:0] rd; logic er; int w, lat, cyc, w0;
        cyc = 0;
        m0_if.req_valid = 1'b1; m0_if.we = 1'b1; m0_if.funct3 = 3'b010; m0_if.addr = 32'h40; m0_if.wdata = 32'h55AA55AA;
        #1;
        while (!m0_if.req_ready && cyc < 20) begin @(posedge clk); #1; cyc++; end
        @(posedge clk); #1;
        m0_if.req_valid = 1'b0;
        checks++; if (mem_write !== 1'b1) begin errors++; $display("FAIL rsta_strobe got %b want 1", mem_write); end
        w0 = wr_cnt;
        rst = 1'b1;
        #1;
        checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL rsta_suppress got %b want 0", mem_write); end
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (wr_cnt != w0 || mem[16] !== 32'h0) begin errors++; $display("FAIL rsta_nowrite got writes=%0d word=%h want 0 0", wr_cnt - w0, mem[16]); end
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (m0_if.rsp_valid !== 1'b0 || mem_write !== 1'b0) begin errors++; $display("FAIL rsta_norsp%0d got v=%b w=%b want 0 0", i, m0_if.rsp_valid, mem_write); end
            @(posedge clk); #1;
        end
        txn(0, 1'b0, 3'b010, 32'h40, 32'h0, rd, er, w, lat);
        checks++; if (rd !== 32'h0 || er !== 1'b0 || w != 0 || lat != 2) begin errors++; $display("FAIL rsta_lw got %h err=%b wait=%0d lat=%0d want 0 0 0 2", rd, er, w, lat); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        m0_if.req_valid = 1'b0; m0_if.addr = '0; m0_if.wdata = '0; m0_if.funct3 = '0; m0_if.we = 1'b0; m0_if.rsp_ready = 1'b0;
        m1_if.req_valid = 1'b0; m1_if.addr = '0; m1_if.wdata = '0; m1_if.funct3 = '0; m1_if.we = 1'b0; m1_if.rsp_ready = 1'b0;
        test_reset();
        test_word();
        test_round_robin();
        test_byte_half();
        test_errors();
        test_backpressure();
        test_reset_in_access();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
